ysyx_ifq: RTL and testbench
===========================

// Module: ysyx_ifq
// PURPOSE
// - Instruction fetch queue between ysyx_ifu (producer) and the decode stage (consumer).
// - Buffers {pc, inst, predecode flags} so a decode stall does not stall L1I lookup.
// - Flushes all entries on a redirect (bad speculation / pc_change) in one cycle.
// - Also counts flushed entries for perf.
// PARAMETERS
// - DATA_W   32  width of pc and instruction words
// - DEPTH_LEN 2  log2 of entry count; DEPTH = 2**DEPTH_LEN (4 entries)
// PORTS
// - clk            in   1       clock
// - rst            in   1       reset, synchronous, active-high
// - flush_i        in   1       discard all entries this cycle (driven by bad_speculation_o)
// - prev_valid     in   1       ifu valid_o: pc_i/inst_i valid
// - pc_i           in   DATA_W  pc of incoming instruction
// - inst_i         in   DATA_W  incoming instruction word
// - ready_o        out  1       queue can accept (feeds ifu next_ready)
// - valid_o        out  1       head entry valid to decode
// - pc_o           out  DATA_W  head pc
// - inst_o         out  DATA_W  head instruction
// - pdec_o         out  4       head predecode {is_fence_i, is_store, is_load, is_branch}
// - next_ready     in   1       decode accepts head this cycle
// - count_o        out  DEPTH_LEN+1  current occupancy
// - flushed_cnt_o  out  32      saturating count of entries discarded by flushes
// BEHAVIOUR
// - Reset: rd/wr pointers 0, count_o=0, valid_o=0, ready_o=1, flushed_cnt_o=0; entry contents don't-care.
// - Pointers are DEPTH_LEN+1 bits; MSB is the wrap bit.
//   - empty = (wr==rd); full = (wr[idx]==rd[idx]) & (wr[MSB]!=rd[MSB]).
// - ready_o = !full (combinational from state only, no dependence on next_ready or flush_i).
// - valid_o = !empty; pc_o/inst_o/pdec_o read storage at rd[idx] directly.
// - enq = prev_valid & ready_o; deq = valid_o & next_ready.
// - Latency: enqueued entry is visible at valid_o the cycle after enq; no same-cycle bypass.
// - enq & deq same cycle: both happen, count unchanged.
//   - When full, enq is blocked; a deq still frees the slot for the next cycle.
// - Pointer wrap: index wraps DEPTH-1 -> 0 and toggles the wrap bit; count = wr - rd, modulo 2**(DEPTH_LEN+1).
// - Predecode computed from inst_i[6:0] at enq and stored with the entry:
//   - is_branch = JAL | JALR | B_TYPE | SYSTEM
//   - is_load = IL_TYPE; is_store = S_TYPE
//   - is_fence_i = (inst_i == FENCE_I)
// - flush_i has priority over enq and deq:
//   - rd <= 0, wr <= 0 (count_o=0 next cycle).
//   - An enq in the same cycle is dropped; a deq in the same cycle still completes on the consumer side.
//   - flushed_cnt_o += count_o - deq (the entries lost), saturating at 32'hFFFF_FFFF.
// - flush_i on an empty queue: no state change except the pointer reset; counter adds 0.
// - rst has priority over flush_i and all handshakes, and takes effect even mid-stream: queue empties next cycle.
// - Storage is written only on enq; no read-modify-write; no X may reach valid_o/ready_o/count_o.
// STRUCTURE
// - Opcode/FENCE_I constants: existing ysyx.svh macros (YSYX_OP_*, YSYX_INST_FENCE_I); no new package entries.
// - Add to ysyx.svh a `define YSYX_IFQ_PDEC_W 4` and the pdec bit-index macros, shared with decode.
// - One sub-module: ysyx_ifq_pdec (combinational inst -> 4-bit predecode); reused later by a BTB refill path.
// - Storage: unpacked arrays pc_q[DEPTH], inst_q[DEPTH], pdec_q[DEPTH]; one always block for pointers/counter.
// TESTING
// - Fill: rst, then 4 enq (pc 0x8000_0000..0x8000_000C), next_ready=0 -> ready_o=0 after 4th, count_o=4, pc_o=0x8000_0000.
// - Drain order: from full, next_ready=1 for 4 cycles -> pc_o 0x..00,04,08,0C in order; then valid_o=0, ready_o=1.
// - Simultaneous: full queue, prev_valid=1 & next_ready=1 -> 1 deq, 0 enq, count 3; next cycle enq accepted, count stays 3.
// - Wrap: stream 10 instrs at full rate with next_ready=1 -> output pc sequence matches input exactly, no drop or duplicate.
// - Flush: 3 entries, flush_i=1 with prev_valid=1 & next_ready=1 -> next cycle count_o=0, valid_o=0, flushed_cnt_o=2.
//   - A later enq of pc 0x8000_0100 appears at head.
// - Predecode: enq 0x0000006F (JAL), 0x00002003 (LW), 0x00002023 (SW), 0x0000100F (FENCE.I).
//   - pdec_o = 4'b0001, 4'b0010, 4'b0100, 4'b1000 respectively.
// - Reset mid-stream: rst with 2 entries -> count_o=0, valid_o=0, flushed_cnt_o=0 next cycle.

Source files
------------

// File: rtl/ysyx_ifq_pkg.sv
// Shared constants for the instruction fetch queue: RV opcodes and predecode bit layout.
package ysyx_ifq_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [31:0] INST_FENCE_I = 32'h0000_100F;

  // Predecode layout {is_fence_i, is_store, is_load, is_branch}; shared with decode.
  localparam int unsigned PDEC_W       = 4;
  localparam int unsigned PDEC_BRANCH  = 0;
  localparam int unsigned PDEC_LOAD    = 1;
  localparam int unsigned PDEC_STORE   = 2;
  localparam int unsigned PDEC_FENCE_I = 3;

  typedef logic [PDEC_W-1:0] pdec_t;

endpackage

// File: rtl/ysyx_ifq_pdec.sv
// Combinational predecode of one instruction word into branch/load/store/fence.i flags.
module ysyx_ifq_pdec
  import ysyx_ifq_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] inst_i,
  output logic [PDEC_W-1:0] pdec_o
);

  logic [6:0] opcode;

  always_comb begin
    opcode = inst_i[6:0];
    pdec_o = '0;
    pdec_o[PDEC_BRANCH]  = (opcode == OP_JAL) | (opcode == OP_JALR) |
                           (opcode == OP_BRANCH) | (opcode == OP_SYSTEM);
    pdec_o[PDEC_LOAD]    = (opcode == OP_LOAD);
    pdec_o[PDEC_STORE]   = (opcode == OP_STORE);
    pdec_o[PDEC_FENCE_I] = (inst_i == DATA_W'(INST_FENCE_I));
  end

endmodule

// File: rtl/ysyx_ifq.sv
// Instruction fetch queue between IFU and decode: buffers {pc, inst, predecode},
// single-cycle flush on redirect, saturating perf count of flushed entries.
module ysyx_ifq
  import ysyx_ifq_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH_LEN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 prev_valid,
  input  logic [DATA_W-1:0]    pc_i,
  input  logic [DATA_W-1:0]    inst_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [DATA_W-1:0]    pc_o,
  output logic [DATA_W-1:0]    inst_o,
  output logic [PDEC_W-1:0]    pdec_o,
  input  logic                 next_ready,
  output logic [DEPTH_LEN:0]   count_o,
  output logic [31:0]          flushed_cnt_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LEN;

  logic [DEPTH_LEN:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0]        flushed_cnt_q, flushed_cnt_d;

  logic [DATA_W-1:0]  pc_q   [DEPTH];
  logic [DATA_W-1:0]  inst_q [DEPTH];
  logic [PDEC_W-1:0]  pdec_q [DEPTH];

  logic [PDEC_W-1:0]  pdec_in;
  logic               empty, full, enq, deq, wr_en;
  logic [DEPTH_LEN:0] lost;
  logic [32:0]        flushed_sum;

  ysyx_ifq_pdec #(.DATA_W(DATA_W)) u_pdec (
    .inst_i (inst_i),
    .pdec_o (pdec_in)
  );

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[DEPTH_LEN-1:0] == rd_q[DEPTH_LEN-1:0]) &
              (wr_q[DEPTH_LEN] != rd_q[DEPTH_LEN]);
    ready_o = !full;
    valid_o = !empty;
    count_o = wr_q - rd_q;
    enq     = prev_valid & ready_o;
    deq     = valid_o & next_ready;
    wr_en   = enq & !flush_i & !rst;

    pc_o    = pc_q[rd_q[DEPTH_LEN-1:0]];
    inst_o  = inst_q[rd_q[DEPTH_LEN-1:0]];
    pdec_o  = pdec_q[rd_q[DEPTH_LEN-1:0]];

    // A same-cycle deq is delivered to decode, so it is not counted as lost.
    lost        = count_o - {{DEPTH_LEN{1'b0}}, deq};
    flushed_sum = {1'b0, flushed_cnt_q} + 33'(lost);

    rd_d          = rd_q + {{DEPTH_LEN{1'b0}}, deq};
    wr_d          = wr_q + {{DEPTH_LEN{1'b0}}, enq};
    flushed_cnt_d = flushed_cnt_q;
    if (flush_i) begin
      rd_d          = '0;
      wr_d          = '0;
      flushed_cnt_d = flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q          <= '0;
      wr_q          <= '0;
      flushed_cnt_q <= '0;
    end else begin
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      flushed_cnt_q <= flushed_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_q[wr_q[DEPTH_LEN-1:0]]   <= pc_i;
      inst_q[wr_q[DEPTH_LEN-1:0]] <= inst_i;
      pdec_q[wr_q[DEPTH_LEN-1:0]] <= pdec_in;
    end
  end

  assign flushed_cnt_o = flushed_cnt_q;

endmodule

// File: tb/tb_ysyx_ifq.sv
// Directed self-checking bench for ysyx_ifq: fill/drain, simultaneous, wrap, flush, predecode, reset.
module tb_ysyx_ifq;

  logic        clk = 1'b0;
  logic        rst, flush_i, prev_valid, next_ready;
  logic [31:0] pc_i, inst_i;
  logic        ready_o, valid_o;
  logic [31:0] pc_o, inst_o, flushed_cnt_o;
  logic [3:0]  pdec_o;
  logic [2:0]  count_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  ysyx_ifq #(.DATA_W(32), .DEPTH_LEN(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .prev_valid    (prev_valid),
    .pc_i          (pc_i),
    .inst_i        (inst_i),
    .ready_o       (ready_o),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .pdec_o        (pdec_o),
    .next_ready    (next_ready),
    .count_o       (count_o),
    .flushed_cnt_o (flushed_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    prev_valid = 1'b1;
    pc_i       = pc;
    inst_i     = inst;
    step();
    prev_valid = 1'b0;
  endtask

  logic [31:0] got_q[$];
  logic [31:0] pd_inst [6];
  logic [3:0]  pd_exp  [6];

  initial begin
    rst = 1'b1; flush_i = 1'b0; prev_valid = 1'b0; next_ready = 1'b0;
    pc_i = '0; inst_i = 32'h0000_0013;
    step(); step();
    rst = 1'b0;
    chk("rst_count", count_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_flushed", flushed_cnt_o, 0);

    // Fill
    for (int i = 0; i < 4; i++) begin
      push(32'h8000_0000 + 32'(4 * i), 32'h0000_0013);
      if (i == 0) chk("fill_latency_valid", valid_o, 1);
    end
    chk("fill_ready", ready_o, 0);
    chk("fill_count", count_o, 4);
    chk("fill_head", pc_o, 32'h8000_0000);

    // Drain
    next_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", pc_o, 32'h8000_0000 + 32'(4 * i));
      step();
    end
    next_ready = 1'b0;
    chk("drain_valid", valid_o, 0);
    chk("drain_ready", ready_o, 1);
    chk("drain_count", count_o, 0);

    // Simultaneous enq/deq from full
    for (int i = 0; i < 4; i++) push(32'h8000_0010 + 32'(4 * i), 32'h0000_0013);
    prev_valid = 1'b1; pc_i = 32'h8000_0020; next_ready = 1'b1;
    chk("sim_head0", pc_o, 32'h8000_0010);
    step();
    chk("sim_count1", count_o, 3);
    chk("sim_ready1", ready_o, 1);
    chk("sim_head1", pc_o, 32'h8000_0014);
    step();
    prev_valid = 1'b0;
    chk("sim_count2", count_o, 3);
    chk("sim_head2", pc_o, 32'h8000_0018);
    step(); step(); step();
    next_ready = 1'b0;
    chk("sim_tail_empty", count_o, 0);

    // Wrap: 10 instructions at full rate
    got_q.delete();
    next_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      prev_valid = (c < 10);
      pc_i       = 32'h9000_0000 + 32'(4 * c);
      if (valid_o && next_ready) got_q.push_back(pc_o);
      step();
    end
    prev_valid = 1'b0; next_ready = 1'b0;
    chk("wrap_len", got_q.size(), 10);
    for (int i = 0; i < 10; i++)
      chk("wrap_pc", (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF, 32'h9000_0000 + 32'(4 * i));

    // Flush with concurrent enq and deq
    for (int i = 0; i < 3; i++) push(32'h8000_0040 + 32'(4 * i), 32'h0000_0013);
    chk("flush_pre_count", count_o, 3);
    flush_i = 1'b1; prev_valid = 1'b1; pc_i = 32'h8000_0050; next_ready = 1'b1;
    step();
    flush_i = 1'b0; prev_valid = 1'b0; next_ready = 1'b0;
    chk("flush_count", count_o, 0);
    chk("flush_valid", valid_o, 0);
    chk("flush_cnt", flushed_cnt_o, 2);
    push(32'h8000_0100, 32'h0000_0013);
    chk("flush_after_head", pc_o, 32'h8000_0100);
    chk("flush_after_count", count_o, 1);
    flush_i = 1'b1;
    step();
    chk("flush_one_cnt", flushed_cnt_o, 3);
    step();
    flush_i = 1'b0;
    chk("flush_empty_cnt", flushed_cnt_o, 3);
    chk("flush_empty_count", count_o, 0);

    // Predecode
    pd_inst[0] = 32'h0000_006F; pd_exp[0] = 4'b0001;
    pd_inst[1] = 32'h0000_2003; pd_exp[1] = 4'b0010;
    pd_inst[2] = 32'h0000_2023; pd_exp[2] = 4'b0100;
    pd_inst[3] = 32'h0000_100F; pd_exp[3] = 4'b1000;
    pd_inst[4] = 32'h0000_0063; pd_exp[4] = 4'b0001;
    pd_inst[5] = 32'h0000_0013; pd_exp[5] = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      push(32'hA000_0000 + 32'(4 * i), pd_inst[i]);
      chk("pdec", pdec_o, pd_exp[i]);
      chk("pdec_inst", inst_o, pd_inst[i]);
      next_ready = 1'b1;
      step();
      next_ready = 1'b0;
    end

    // Reset mid-stream
    push(32'h8000_0200, 32'h0000_0013);
    push(32'h8000_0204, 32'h0000_0013);
    chk("mid_pre_count", count_o, 2);
    rst = 1'b1; prev_valid = 1'b1; next_ready = 1'b1; flush_i = 1'b1;
    step();
    rst = 1'b0; prev_valid = 1'b0; next_ready = 1'b0; flush_i = 1'b0;
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_flushed", flushed_cnt_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
